// File: rtl/sub_serial_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Optional signed-overflow flag is enabled by defining SUB_OVERFLOW_EN.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    function automatic int cnt_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full-subtractor cell: diff = x - y - br, bo = borrow out.
// Shared by the serial datapath and reusable as a cell-library unit.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ br;
    assign bo   = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/subtractor_4bit_serial.sv
// Bit-serial subtractor {bout,d} = a - b - bin, LSB first through one cell.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module subtractor_4bit_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-2:0] dsr;
    logic [WIDTH-1:0] d_next;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             cell_diff;
    logic             cell_bo;
    logic             last;
    logic             accept;
`ifdef SUB_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    full_subtractor_1bit u_cell (
        .x    (shift_a[0]),
        .y    (shift_b[0]),
        .br   (borrow),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    assign last   = (count == LAST);
    assign accept = in_valid && in_ready;
    // Partial difference grows from the MSB side; full word on the last shift.
    assign d_next = {cell_diff, dsr};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            dsr     <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            d       <= '0;
            bout    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            shift_a <= a;
            shift_b <= b;
            borrow  <= bin;
            count   <= '0;
`ifdef SUB_OVERFLOW_EN
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            dsr     <= d_next[WIDTH-1:1];
            borrow  <= cell_bo;
            count   <= count + CW'(1);
            if (last) begin
                d    <= d_next;
                bout <= cell_bo;
`ifdef SUB_OVERFLOW_EN
                ovf  <= (a_msb != b_msb) && (cell_diff != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_subtractor_4bit_serial.sv
// Directed and exhaustive checks for the bit-serial subtractor.
// Overflow checks are compiled in when SUB_OVERFLOW_EN is defined.
module tb_subtractor_4bit_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] d;
    logic       bout;
`ifdef SUB_OVERFLOW_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    subtractor_4bit_serial #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef SUB_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .bout      (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Launch one operation; returns at the negedge where out_valid is seen
    // (or the bound expires). lat counts edges with the accept edge as 1.
    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib,
                         input logic ibin, input logic ordy,
                         output int lat);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        a         = ia;
        b         = ib;
        bin       = ibin;
        in_valid  = 1'b1;
        out_ready = ordy;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        bin      = 1'($urandom);
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        logic [4:0] ref5;
        logic [3:0] d0;
        logic       b0;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0};
        vecs[3] = '{4'd9,  4'd4,  1'b1, 4'd4,  1'b0, 1'b1};
        vecs[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        vecs[5] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0};
        vecs[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[7] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[8] = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
        vecs[9] = '{4'd6,  4'd2,  1'b0, 4'd4,  1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_d", 32'(d), 0);
        check("rst_bout", 32'(bout), 0);
`ifdef SUB_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1, lat);
            check($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].d));
            check($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            check($sformatf("vec%0d_lat", i), lat, 5);
`ifdef SUB_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
`endif
        end

        for (int i = 0; i < 512; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ebin;
            ea   = 4'(i >> 5);
            eb   = 4'(i >> 1);
            ebin = 1'(i);
            ref5 = {1'b0, ea} - {1'b0, eb} - {4'd0, ebin};
            do_op(ea, eb, ebin, 1'b1, lat);
            check($sformatf("exh_%0d_%0d_%0d", ea, eb, ebin),
                  32'({bout, d}), 32'(ref5));
`ifdef SUB_OVERFLOW_EN
            check($sformatf("exh_ovf_%0d_%0d_%0d", ea, eb, ebin), 32'(ovf),
                  32'((ea[3] != eb[3]) && (ref5[3] != ea[3])));
`endif
        end

        // Backpressure: result held, new request refused
        do_op(4'd12, 4'd5, 1'b0, 1'b0, lat);
        d0 = d;
        b0 = bout;
        check("bp_d", 32'(d0), 7);
        check("bp_bout", 32'(b0), 0);
        for (int i = 0; i < 10; i++) begin
            a        = 4'd1;
            b        = 4'd2;
            bin      = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold", 32'({out_valid, in_ready, bout, d}),
                  32'({1'b1, 1'b0, b0, d0}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 32'({out_valid, in_ready}), 32'(2'b01));
        check("bp_d_kept", 32'({bout, d}), 32'({b0, d0}));

        // Reset in the middle of SHIFT
        @(negedge clk);
        a        = 4'd3;
        b        = 4'd3;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_valid", 32'(out_valid), 0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            check("mid_rst_no_output", 32'(seen), 0);
        end
        do_op(4'd9, 4'd4, 1'b1, 1'b1, lat);
        check("post_rst_d", 32'(d), 4);
        check("post_rst_bout", 32'(bout), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
